// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, opcode/func constants
// and instruction field slices used by fetch and the control decoder.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } ifu_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_JR  = 6'h08;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  function automatic logic [5:0] f_op(
    input logic [31:0] ir
  );
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(
    input logic [31:0] ir
  );
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(
    input logic [31:0] ir
  );
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(
    input logic [31:0] ir
  );
    return ir[15:11];
  endfunction

  function automatic logic [5:0] f_func(
    input logic [31:0] ir
  );
    return ir[5:0];
  endfunction

  function automatic logic [15:0] f_imm16(
    input logic [31:0] ir
  );
    return ir[15:0];
  endfunction

  function automatic logic [25:0] f_target26(
    input logic [31:0] ir
  );
    return ir[25:0];
  endfunction

  // Word offset of a branch: sign-extended imm16 scaled by 4.
  function automatic logic [31:0] f_br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux for the fetch stage: jr > j/jal > bne > sequential.
// Purely combinational; all arithmetic wraps at 32 bits.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic        i_pc_src,
  input  logic        i_jump_enable,
  input  logic        i_branch_taken,
  input  logic [29:0] i_jr_word,
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_target26,
  input  logic [15:0] i_imm16,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_jr_pc;
  logic [31:0] w_jmp_pc;
  logic [31:0] w_br_pc;

  assign w_jr_pc  = {i_jr_word, 2'b00};
  assign w_jmp_pc = {i_pc_plus4[31:28], i_target26, 2'b00};
  assign w_br_pc  = i_pc_plus4 + f_br_off(i_imm16);

  // Several redirects may be raised at once; the first one wins.
  always_comb begin
    o_next_pc = i_pc_plus4;
    priority case (1'b1)
      i_pc_src:       o_next_pc = w_jr_pc;
      i_jump_enable:  o_next_pc = w_jmp_pc;
      i_branch_taken: o_next_pc = w_br_pc;
      default:        o_next_pc = i_pc_plus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, imem req/ack, IR and decoder valid/ready.
// Optional IFU_PERF_CNT_EN adds fetch_count/stall_count outputs.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic [31:0] pc_plus4,
  input  logic        jump_enable,
  input  logic        pc_src,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  output logic        fetch_timeout,
  output logic        addr_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned TO_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  ifu_state_e    r_state;
  ifu_state_e    w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_ir;
  logic [31:0]   w_next_pc;
  logic          w_consume;
  logic          w_ack;
  logic          w_miss;
  logic          w_to_hit;
  logic [TO_W-1:0] r_to_cnt;
  logic          r_timeout;
  logic          r_addr_err;

  assign w_consume = inst_valid & inst_ready;
  assign w_ack     = imem_req & imem_ack;
  assign w_miss    = imem_req & ~imem_ack;
  assign w_to_hit  = TO_EN & w_miss & (r_to_cnt == TO_LAST);

  assign imem_addr = r_pc;
  assign pc_plus4  = r_pc + 32'd4;
  assign op        = f_op(r_ir);
  assign func      = f_func(r_ir);
  assign rs        = f_rs(r_ir);
  assign rt        = f_rt(r_ir);
  assign rd        = f_rd(r_ir);
  assign imm16     = f_imm16(r_ir);
  assign target26  = f_target26(r_ir);

  assign fetch_timeout = r_timeout;
  assign addr_err      = r_addr_err;

  next_pc_sel u_next_pc_sel (
    .i_pc_src       (pc_src),
    .i_jump_enable  (jump_enable),
    .i_branch_taken (branch_taken),
    .i_jr_word      (jr_addr[31:2]),
    .i_pc_plus4     (pc_plus4),
    .i_target26     (target26),
    .i_imm16        (imm16),
    .o_next_pc      (w_next_pc)
  );

  // State register; req drops as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs decoded from the state.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) w_state_nxt = S_FETCH;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // PC advances only when the held instruction is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pc <= RESET_PC;
    else if (w_consume) r_pc <= w_next_pc;
  end

  // Instruction register captures the acked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ir <= '0;
    else if (w_ack) r_ir <= imem_rdata;
  end

  // Unacked-request counter; saturates once the limit is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_to_cnt <= '0;
    else if (!w_miss)          r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_to_hit) r_timeout <= 1'b1;
      if (w_consume && pc_src && (jr_addr[1:0] != 2'b00))
        r_addr_err <= 1'b1;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall     = w_miss | (inst_valid & ~inst_ready);
  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
